// File: rtl/logic_unit_pipe_if.sv
// Valid/ready stream bundle for logic_unit_pipe: operand/op request channel
// plus result/flag response channel.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int PW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             zero;
  logic             parity;
  logic [PW-1:0]    popcnt;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, R, zero, parity, popcnt
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, R, zero, parity, popcnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit: 8-op bitwise result plus zero/parity/popcount flags,
// STAGES-deep valid/ready pipeline stallable by the downstream consumer.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_unit_pipe_if.slave bus
);
  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r1_d;
  logic [STAGES:1]  vld_q;
  logic [STAGES:1]  rdy;
  logic [WIDTH-1:0] r_q [1:STAGES];
  logic             zeroOut;
  logic             parityOut;
  logic [PW-1:0]    popOut;

  function automatic logic [PW-1:0] popCount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  always_comb begin
    r1_d = '0;
    case (bus.op)
      3'b000:  r1_d = bus.A & bus.B;
      3'b001:  r1_d = bus.A | bus.B;
      3'b010:  r1_d = bus.A ^ bus.B;
      3'b011:  r1_d = ~(bus.A | bus.B);
      3'b100:  r1_d = ~(bus.A & bus.B);
      3'b101:  r1_d = ~(bus.A ^ bus.B);
      3'b110:  r1_d = ~bus.A;
      default: r1_d = bus.A;
    endcase
  end

  // Stage k can load unless it and every stage after it is full while the consumer stalls.
  always_comb begin
    logic allFull;
    allFull = 1'b1;
    rdy     = '0;
    for (int k = STAGES; k >= 1; k--) begin
      allFull = allFull & vld_q[k];
      rdy[k]  = bus.out_ready | ~allFull;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (rdy[1]) vld_q[1] <= bus.in_valid;
      for (int k = 2; k <= STAGES; k++) begin
        if (rdy[k]) vld_q[k] <= vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy[1] && bus.in_valid) r_q[1] <= r1_d;
    for (int k = 2; k <= STAGES; k++) begin
      if (rdy[k] && vld_q[k-1]) r_q[k] <= r_q[k-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_flagsComb
      always_comb begin
        zeroOut   = (r_q[1] == '0);
        parityOut = ^r_q[1];
        popOut    = popCount(r_q[1]);
      end
    end else begin : g_flagsReg
      logic [STAGES:2] zero_q;
      logic [STAGES:2] parity_q;
      logic [PW-1:0]   pop_q [2:STAGES];

      // Flags are derived from the stage-1 result and then ride along with it.
      always_ff @(posedge clk) begin
        if (rdy[2] && vld_q[1]) begin
          zero_q[2]   <= (r_q[1] == '0);
          parity_q[2] <= ^r_q[1];
          pop_q[2]    <= popCount(r_q[1]);
        end
        for (int k = 3; k <= STAGES; k++) begin
          if (rdy[k] && vld_q[k-1]) begin
            zero_q[k]   <= zero_q[k-1];
            parity_q[k] <= parity_q[k-1];
            pop_q[k]    <= pop_q[k-1];
          end
        end
      end

      assign zeroOut   = zero_q[STAGES];
      assign parityOut = parity_q[STAGES];
      assign popOut    = pop_q[STAGES];
    end
  endgenerate

  // Outputs are forced to zero whenever no item is presented.
  assign bus.in_ready  = rdy[1];
  assign bus.out_valid = vld_q[STAGES];
  assign bus.R         = vld_q[STAGES] ? r_q[STAGES] : '0;
  assign bus.zero      = vld_q[STAGES] & zeroOut;
  assign bus.parity    = vld_q[STAGES] & parityOut;
  assign bus.popcnt    = vld_q[STAGES] ? popOut : '0;
endmodule
